// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv
//   Execute-stage ALU with registered results behind a start/busy/done
//   handshake. AND/OR/ADD/SUB/SLT(signed)/NOR complete in one edge;
//   MUL (shift-add) and DIVU/REMU (restoring) take WIDTH edges.
//   Division by zero takes the single-edge path and flags div_by_zero.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       request, sampled only while idle
//   control     4-bit opcode, latched with start
//   inA, inB    operands, latched with start
//   alu_out     registered result
//   zero        registered, 1 iff alu_out == 0
//   busy        high while an iterative op runs
//   done        one-cycle pulse when alu_out/zero are updated
//   div_by_zero registered, set with done for DIVU/REMU by zero
module alu_seq_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             is_mul_q, is_mul_d;
    logic             is_rem_q, is_rem_d;
    // x: MUL multiplier (shifts right) / DIV dividend-then-quotient (shifts left)
    // y: MUL multiplicand (shifts left) / DIV divisor (constant)
    // acc: MUL partial product / DIV partial remainder
    logic [WIDTH-1:0] x_q,   x_d;
    logic [WIDTH-1:0] y_q,   y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q,  dbz_d;

    logic             is_div_op;
    logic             is_iter;
    logic             slt_lt;
    logic [WIDTH-1:0] single_res;

    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH-1:0] div_low;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_nx;
    logic [WIDTH-1:0] div_x_nx;
    logic [WIDTH-1:0] fin_res;

    assign is_div_op = (control == OP_DIVU) || (control == OP_REMU);
    assign is_iter   = (control == OP_MUL) || (is_div_op && (inB != '0));
    assign slt_lt    = $signed(inA) < $signed(inB);

    always_comb begin
        single_res = inA;
        case (control)
            OP_AND:  single_res = inA & inB;
            OP_OR:   single_res = inA | inB;
            OP_ADD:  single_res = inA + inB;
            OP_SUB:  single_res = inA - inB;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, slt_lt};
            OP_NOR:  single_res = ~(inA | inB);
            OP_DIVU: single_res = '1;   // only reached with inB == 0
            OP_REMU: single_res = inA;  // only reached with inB == 0
            default: single_res = inA;
        endcase
    end

    // One shift-add step.
    assign mul_acc_nx = acc_q + (x_q[0] ? y_q : '0);

    // One restoring-division step. The shifted remainder is WIDTH+1 bits;
    // if its top bit is set it already exceeds any divisor, and the true
    // difference always fits in WIDTH bits, so the extra bit is never stored.
    assign div_low    = {acc_q[WIDTH-2:0], x_q[WIDTH-1]};
    assign div_ge     = acc_q[WIDTH-1] || (div_low >= y_q);
    assign div_rem_nx = div_ge ? (div_low - y_q) : div_low;
    assign div_x_nx   = {x_q[WIDTH-2:0], div_ge};

    assign fin_res = is_mul_q ? mul_acc_nx : (is_rem_q ? div_rem_nx : div_x_nx);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        is_rem_d = is_rem_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        res_d    = res_q;
        zero_d   = zero_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_iter) begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        cnt_d    = '0;
                        is_mul_d = (control == OP_MUL);
                        is_rem_d = (control == OP_REMU);
                        x_d      = inA;
                        y_d      = inB;
                        acc_d    = '0;
                    end else begin
                        res_d  = single_res;
                        zero_d = (single_res == '0);
                        dbz_d  = is_div_op;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_mul_q) begin
                    acc_d = mul_acc_nx;
                    x_d   = x_q >> 1;
                    y_d   = y_q << 1;
                end else begin
                    acc_d = div_rem_nx;
                    x_d   = div_x_nx;
                end
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    res_d   = fin_res;
                    zero_d  = (fin_res == '0);
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            is_rem_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            is_rem_q <= is_rem_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign alu_out     = res_q;
    assign zero        = zero_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv (WIDTH=32) plus a directed
// check of a WIDTH=8 instance.
module tb_alu_seq_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  control;
    logic [31:0] inA, inB;
    logic [31:0] alu_out;
    logic        zero, busy, done, div_by_zero;

    logic        start8;
    logic [3:0]  control8;
    logic [7:0]  inA8, inB8;
    logic [7:0]  alu_out8;
    logic        zero8, busy8, done8, dbz8;

    always #5 clk = ~clk;

    alu_seq_muldiv #(.WIDTH(32), .CNT_W(6)) u_dut (
        .clk(clk), .rst(rst), .start(start), .control(control),
        .inA(inA), .inB(inB), .alu_out(alu_out), .zero(zero),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    alu_seq_muldiv #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .control(control8),
        .inA(inA8), .inB(inB8), .alu_out(alu_out8), .zero(zero8),
        .busy(busy8), .done(done8), .div_by_zero(dbz8)
    );

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int unsigned lat;
        int unsigned start_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned busy_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            4'b1000: return a * b;
            4'b1010: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'b1011: return (b == 0) ? a : a % b;
            default: return a;
        endcase
    endfunction

    function automatic int unsigned model_lat(input logic [3:0] c, input logic [31:0] b);
        if (c == 4'b1000) return 32;
        if ((c == 4'b1010 || c == 4'b1011) && b != 0) return 32;
        return 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: every done pulse must match the oldest pending request.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", alu_out, mon_e.res);
                    chk("zero", zero, (mon_e.res == 0));
                    chk("div_by_zero", div_by_zero, mon_e.dbz);
                    chk("latency", cyc - mon_e.start_cyc, mon_e.lat);
                    chk("busy_cycles", busy_cnt, mon_e.lat);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive a request at the current negedge and record its expectation.
    task automatic apply(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        control = c;
        inA     = a;
        inB     = b;
        start   = 1'b1;
        e.res       = model(c, a, b);
        e.dbz       = (c == 4'b1010 || c == 4'b1011) && (b == 0);
        e.lat       = model_lat(c, b);
        e.start_cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        apply(c, a, b);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        issue(c, a, b);
        idle();
        wait_empty();
    endtask

    task automatic run8(input string tag, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_res, input int unsigned exp_busy);
        int unsigned bc;
        bit seen;
        @(negedge clk);
        control8 = c;
        inA8     = a;
        inB8     = b;
        start8   = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        bc   = 0;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            if (done8) begin
                seen = 1;
                break;
            end
            if (busy8) bc++;
            @(negedge clk);
        end
        chk({tag, "_done"}, seen, 1);
        chk({tag, "_res"}, alu_out8, exp_res);
        chk({tag, "_zero"}, zero8, (exp_res == 0));
        chk({tag, "_busy"}, bc, exp_busy);
    endtask

    logic [3:0] ops [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                             4'b1100, 4'b1000, 4'b1010, 4'b1011, 4'b0011, 4'b1111};

    initial begin
        rst = 1'b1; start = 1'b0; control = '0; inA = '0; inB = '0;
        start8 = 1'b0; control8 = '0; inA8 = '0; inB8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_alu_out", alu_out, 0);
        chk("rst_zero", zero, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        rst = 1'b0;

        // Signed SLT and SUB to zero
        run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF);
        run_op(4'b0110, 32'd5, 32'd5);

        // Multiply
        run_op(4'b1000, 32'h0001_0001, 32'h0000_FFFF);
        run_op(4'b1000, 32'h8000_0000, 32'd2);

        // Divide / remainder, including divide by zero
        run_op(4'b1010, 32'd100, 32'd7);
        run_op(4'b1011, 32'd100, 32'd7);
        run_op(4'b1010, 32'd5, 32'd0);
        run_op(4'b1011, 32'd5, 32'd0);
        run_op(4'b1010, 32'hFFFF_FFFF, 32'h8000_0001);

        // Undefined opcode passes inA through
        run_op(4'b0101, 32'hDEAD_BEEF, 32'h1234_5678);

        // Start while busy is ignored; operand changes do not disturb the op
        issue(4'b1010, 32'd100, 32'd7);
        idle();
        repeat (3) @(negedge clk);
        control = 4'b0010; inA = 32'd1; inB = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; inA = 32'hFFFF_FFFF; inB = 32'd3;
        wait_empty();
        repeat (3) @(negedge clk);

        // Start accepted in the done cycle
        issue(4'b1011, 32'd1000, 32'd33);
        idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
        end
        apply(4'b0010, 32'd40, 32'd2);
        idle();
        wait_empty();

        // Single-cycle ops issued every cycle
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(4'b0001, 32'h0000_0000, 32'h0000_0000);
        issue(4'b1100, 32'h0F0F_0000, 32'h0000_F0F0);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1);
        idle();
        wait_empty();

        // Random mix through the scoreboard
        for (int i = 0; i < 12; i++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            c = ops[$urandom_range(0, 10)];
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            run_op(c, a, b);
        end

        // Reset in the middle of a multiply aborts it
        issue(4'b1000, 32'h1234_5678, 32'h0000_0003);
        idle();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_alu_out", alu_out, 0);
        chk("abort_zero", zero, 1);
        repeat (40) @(negedge clk);
        run_op(4'b0010, 32'd3, 32'd4);

        // Narrow instance
        run8("w8_mul", 4'b1000, 8'h10, 8'h10, 8'h00, 8);
        run8("w8_divu", 4'b1010, 8'd200, 8'd9, 8'd22, 8);
        run8("w8_remu", 4'b1011, 8'd200, 8'd9, 8'd2, 8);
        run8("w8_add", 4'b0010, 8'hFF, 8'h02, 8'h01, 0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
